cond_exec_sequencer: RTL
========================

# cond_exec_sequencer

Execute-stage sequencer for the pipelined ARM-subset core. It owns the architectural NZCV status register and decides per instruction whether it executes, using its 4-bit condition field against the current flags. It gates the instruction's write-back, memory-write and flag-update side effects, and squashes the younger instructions that follow a taken branch for a fixed number of cycles. A saturating counter records squashed instructions for performance debug.

## Interface
- `FLUSH_CYCLES`, default 2: cycles of squash after a taken branch (range 1–7).
- `CNT_W`, default 8: width of the squash counter.

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an instruction is presented.
- `in_ready`  out  1  the sequencer accepts; equals `~freeze`.
- `in_cond`  in  4  condition field.
- `in_s`  in  1  the instruction updates flags.
- `in_is_branch`  in  1  the instruction is a branch.
- `in_wb_en`  in  1  requested register write-back.
- `in_mem_wr`  in  1  requested memory write.
- `alu_status`  in  4  ALU flags for this instruction, `{C,N,V,Z}` (bit 3 = C, bit 0 = Z).
- `freeze`  in  1  pipeline hazard stall.
- `status_q`  out  4  architectural flags, `{C,N,V,Z}`.
- `exec_valid`  out  1  registered: the accepted instruction executed.
- `wb_en_o`  out  1  registered gated write-back.
- `mem_wr_o`  out  1  registered gated memory write.
- `branch_taken`  out  1  registered one-cycle pulse.
- `flush`  out  1  high while in state FLUSH.
- `squash_cnt`  out  `CNT_W`  saturating count of squashed instructions.

## Operation
- Accept = `in_valid & in_ready`.
- The condition passes when the code below evaluates true against `status_q`, i.e. the flags from before this instruction's own update:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z.
  - GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL 1, 1111 (NV) 0.
- An instruction is live when it is accepted and state is RUN.
- An instruction executes when it is live and its condition passes.
- When an instruction executes, its side effects are:
  - `wb_en_o` = `in_wb_en` and `mem_wr_o` = `in_mem_wr`, registered;
  - `exec_valid` = 1, registered;
  - if `in_s`, `status_q <= alu_status`;
  - if `in_is_branch`, `branch_taken` pulses and state moves to FLUSH with `fcnt = FLUSH_CYCLES-1`.
- An instruction is squashed when it is accepted and either state is FLUSH or its condition fails. A squashed instruction has:
  - all registered outputs 0;
  - no flag update;
  - `squash_cnt` incremented, saturating at all-ones.
- State machine:
  - RUN → FLUSH on an executed branch.
  - FLUSH: each non-frozen cycle, if `fcnt == 0` go to RUN, else decrement `fcnt`.
  - The FLUSH count runs on elapsed non-frozen cycles, whether or not `in_valid` is high.
- Freeze: state, `fcnt`, `status_q` and `squash_cnt` all hold, and the registered outputs go to 0 (bubble).
- No accept (`in_valid` = 0, no freeze): the registered outputs go to 0.

## Timing
- Reset (asynchronous, any state, including mid-FLUSH):
  - `status_q` = 0, state = RUN, `fcnt` = 0, `squash_cnt` = 0;
  - `exec_valid`, `wb_en_o`, `mem_wr_o`, `branch_taken` and `flush` all = 0.
- Latency:
  - Registered outputs appear 1 cycle after the accept edge.
  - `status_q` updates at the accept edge and is visible to the instruction in the next cycle (back-to-back forwarding through the register).
- `flush` rises in the cycle after the branch accept and stays high for exactly `FLUSH_CYCLES` non-frozen cycles.
- Simultaneous events:
  - A taken branch with `in_s` = 1 both updates the flags and starts FLUSH.
  - `freeze` together with `in_valid` is not an accept.
  - A branch cannot be taken inside FLUSH, because it is squashed.
- `squash_cnt` saturates; it does not wrap.

## Structure
- Package `cond_pkg` holds:
  - the condition-code localparams (EQ … NV);
  - the flag bit indices `C_BIT`=3, `N_BIT`=2, `V_BIT`=1, `Z_BIT`=0;
  - the state enum RUN/FLUSH.
- Sub-module `cond_eval` is purely combinational (`cond`, `flags` → `pass`) and is instantiated once; the sequencer holds all state.

## Test plan
- **Reset then Z-dependent pair.** After reset, `in_cond`=0000 (EQ) → `exec_valid`=0, `squash_cnt`=1. Then an accept with `in_s`=1, `alu_status`=0001 → `status_q`=0001; the next EQ instruction executes with `wb_en_o`=1.
- **Condition table sweep.** All 16 codes × all 16 flag values, each checked against a reference model; LS and LE must be true at Z=1; NV is never executed.
- **Taken branch, `FLUSH_CYCLES`=2.**
  - Stimulus: branch AL at cycle t, then 3 valid instructions.
  - Required: `branch_taken` high at t+1; `flush` high at t+1 and t+2; the instructions at t+1 and t+2 are squashed (`squash_cnt` +2); the instruction at t+3 executes.
- **Freeze during FLUSH.** `freeze` held for 3 cycles at t+1 → `flush` stays high for 2 + 3 cycles, `status_q` unchanged, `in_ready`=0 throughout the freeze.
- **Reset mid-FLUSH.** `rst_n` pulsed low at t+1 → `flush`=0 immediately, `status_q`=0, and the next AL instruction executes.
- **Saturation.** 300 NV instructions with `CNT_W`=8 → `squash_cnt`=255 and it holds there.

Source files
------------

// File: rtl/cond_pkg.sv
`default_nettype none
//============================================================================
// Module      : cond_pkg
// Description : Shared definitions for the conditional-execution sequencer:
//               ARM condition-code encodings, NZCV flag bit positions
//               (status word is {C,N,V,Z}) and the sequencer state type.
// Revision    : 1.0 - initial release
//============================================================================
package cond_pkg;

    // Condition-code field encodings
    localparam logic [3:0] EQ = 4'b0000;
    localparam logic [3:0] NE = 4'b0001;
    localparam logic [3:0] CS = 4'b0010;
    localparam logic [3:0] CC = 4'b0011;
    localparam logic [3:0] MI = 4'b0100;
    localparam logic [3:0] PL = 4'b0101;
    localparam logic [3:0] VS = 4'b0110;
    localparam logic [3:0] VC = 4'b0111;
    localparam logic [3:0] HI = 4'b1000;
    localparam logic [3:0] LS = 4'b1001;
    localparam logic [3:0] GE = 4'b1010;
    localparam logic [3:0] LT = 4'b1011;
    localparam logic [3:0] GT = 4'b1100;
    localparam logic [3:0] LE = 4'b1101;
    localparam logic [3:0] AL = 4'b1110;
    localparam logic [3:0] NV = 4'b1111;

    // Bit positions inside the 4-bit status word {C,N,V,Z}
    localparam int C_BIT = 3;
    localparam int N_BIT = 2;
    localparam int V_BIT = 1;
    localparam int Z_BIT = 0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_t;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
//============================================================================
// Module      : cond_eval
// Description : Purely combinational condition-code evaluator. Decides
//               whether a 4-bit condition field is satisfied by the given
//               {C,N,V,Z} flags.
// Ports       : cond  [3:0] in  - condition field
//               flags [3:0] in  - status flags {C,N,V,Z}
//               pass        out - condition satisfied
// Revision    : 1.0 - initial release
//============================================================================
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_c;
    logic w_n;
    logic w_v;
    logic w_z;

    assign w_c = flags[C_BIT];
    assign w_n = flags[N_BIT];
    assign w_v = flags[V_BIT];
    assign w_z = flags[Z_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ:      pass = w_z;
            NE:      pass = ~w_z;
            CS:      pass = w_c;
            CC:      pass = ~w_c;
            MI:      pass = w_n;
            PL:      pass = ~w_n;
            VS:      pass = w_v;
            VC:      pass = ~w_v;
            HI:      pass = w_c & ~w_z;
            LS:      pass = ~w_c | w_z;
            GE:      pass = (w_n == w_v);
            LT:      pass = (w_n != w_v);
            GT:      pass = ~w_z & (w_n == w_v);
            LE:      pass = w_z | (w_n != w_v);
            AL:      pass = 1'b1;
            default: pass = 1'b0;   // NV never executes
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/cond_exec_sequencer.sv
`default_nettype none
//============================================================================
// Module      : cond_exec_sequencer
// Description : Execute-stage sequencer. Owns the NZCV status register,
//               evaluates each instruction's condition against it, gates
//               write-back / memory-write / flag-update side effects and
//               squashes the instructions that follow a taken branch for
//               FLUSH_CYCLES non-frozen cycles. Squashed instructions are
//               counted in a saturating counter.
// Ports       : clk, rst_n (async, active low)
//               in_valid, in_cond[3:0], in_s, in_is_branch, in_wb_en,
//               in_mem_wr, alu_status[3:0], freeze         - inputs
//               in_ready                                   - ~freeze
//               status_q[3:0]                              - flags {C,N,V,Z}
//               exec_valid, wb_en_o, mem_wr_o, branch_taken - registered
//               flush                                      - state is FLUSH
//               squash_cnt[CNT_W-1:0]                      - squash count
// Revision    : 1.0 - initial release
//============================================================================
module cond_exec_sequencer
    import cond_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic             in_s,
    input  logic             in_is_branch,
    input  logic             in_wb_en,
    input  logic             in_mem_wr,
    input  logic [3:0]       alu_status,
    input  logic             freeze,
    output logic [3:0]       status_q,
    output logic             exec_valid,
    output logic             wb_en_o,
    output logic             mem_wr_o,
    output logic             branch_taken,
    output logic             flush,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [2:0]       c_fcnt_init = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    seq_state_t       r_state;
    logic [2:0]       r_fcnt;
    logic [3:0]       r_status;
    logic [CNT_W-1:0] r_squash_cnt;
    logic             r_exec_valid;
    logic             r_wb_en;
    logic             r_mem_wr;
    logic             r_branch_taken;

    logic w_pass;
    logic w_accept;
    logic w_exec;
    logic w_squash;

    // Condition is judged against the committed flags, so a flag-setting
    // instruction is seen by the very next one through r_status.
    cond_eval u_cond_eval (
        .cond  (in_cond),
        .flags (r_status),
        .pass  (w_pass)
    );

    assign in_ready = ~freeze;
    assign w_accept = in_valid & ~freeze;
    assign w_exec   = w_accept & (r_state == RUN) & w_pass;
    assign w_squash = w_accept & ((r_state == FLUSH) | ~w_pass);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_fcnt         <= 3'd0;
            r_status       <= 4'd0;
            r_squash_cnt   <= '0;
            r_exec_valid   <= 1'b0;
            r_wb_en        <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_branch_taken <= 1'b0;
        end else begin
            // w_exec is already zero on freeze or no accept, which gives
            // the bubble on the registered outputs for free.
            r_exec_valid   <= w_exec;
            r_wb_en        <= w_exec & in_wb_en;
            r_mem_wr       <= w_exec & in_mem_wr;
            r_branch_taken <= w_exec & in_is_branch;

            if (w_exec && in_s) begin
                r_status <= alu_status;
            end

            if (w_squash && (r_squash_cnt != c_cnt_max)) begin
                r_squash_cnt <= r_squash_cnt + CNT_W'(1);
            end

            // The flush window counts elapsed non-frozen cycles, not
            // accepted instructions.
            if (!freeze) begin
                case (r_state)
                    RUN: begin
                        if (w_exec && in_is_branch) begin
                            r_state <= FLUSH;
                            r_fcnt  <= c_fcnt_init;
                        end
                    end
                    FLUSH: begin
                        if (r_fcnt == 3'd0) begin
                            r_state <= RUN;
                        end else begin
                            r_fcnt <= r_fcnt - 3'd1;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign status_q     = r_status;
    assign exec_valid   = r_exec_valid;
    assign wb_en_o      = r_wb_en;
    assign mem_wr_o     = r_mem_wr;
    assign branch_taken = r_branch_taken;
    assign flush        = (r_state == FLUSH);
    assign squash_cnt   = r_squash_cnt;

endmodule : cond_exec_sequencer
`default_nettype wire
